team_06_sram_arbiter: RTL and testbench
=======================================

Name: team_06_sram_arbiter

Overview:
- Shares the single wishbone_manager user-side port (and the SRAM behind it) between two requesters.
- Requester A is the real-time audio delay/echo path (team_06_readWrite). Requester B is the non-real-time path (ESP/SPI playback buffer, debug dump).
- The block arbitrates, latches the winning command, issues a one-cycle read/write strobe, tracks the manager's BUSY_O, and returns read data plus a done pulse to the winner.
- It sits between the requesters and wishbone_manager in team_06.

Parameters:
- TIMEOUT_CYC, 16, max cycles in WAIT_START for mgr_busy to rise before the transaction is aborted with an error.
- CNT_W, $clog2(TIMEOUT_CYC+1), width of the timeout counter (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_a  input  1  requester A transaction request, level, held until done_a
- we_a  input  1  A: 1=write, 0=read; stable while req_a high
- addr_a  input  32  A byte address
- wdata_a  input  32  A write data
- sel_a  input  4  A byte selects
- done_a  output  1  one-cycle pulse: A's transaction finished
- err_a  output  1  one-cycle pulse with done_a: A's transaction timed out
- rdata_a  output  32  last read data returned to A
- req_b, we_b, addr_b, wdata_b, sel_b, done_b, err_b, rdata_b: same as A, for requester B
- mgr_wdata  output  32  to CPU_DAT_I
- mgr_addr  output  32  to ADR_I
- mgr_sel  output  4  to SEL_I
- mgr_write  output  1  to WRITE_I, one-cycle strobe
- mgr_read  output  1  to READ_I, one-cycle strobe
- mgr_rdata  input  32  from CPU_DAT_O
- mgr_busy  input  1  from BUSY_O

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; mgr_write, mgr_read, done_*, err_* = 0; mgr_wdata, mgr_addr, rdata_a, rdata_b = 0; mgr_sel = 4'h0; counter = 0; last_gnt = B, so A wins the first tie.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE.
- IDLE:
  - No req: stay.
  - Exactly one req high: grant it.
  - Both high: grant the requester not equal to last_gnt (round-robin).
  - On grant: latch we, addr, wdata, sel into the mgr_* holding registers, record gnt, go ISSUE.
- ISSUE (1 cycle): mgr_write=we_latched, mgr_read=~we_latched; clear counter; go WAIT_START.
- WAIT_START:
  - mgr_busy=1: go WAIT_DONE.
  - Otherwise increment counter. When counter reaches TIMEOUT_CYC-1 with mgr_busy still 0: set the err flag, go DONE.
- WAIT_DONE: stay while mgr_busy=1. On mgr_busy=0: if the command was a read, capture mgr_rdata into rdata_{gnt}; go DONE.
- DONE (1 cycle): done_{gnt}=1; err_{gnt}=err flag; last_gnt=gnt; clear err flag; go IDLE.
- Strobe and output decode: mgr_write and mgr_read are decoded from registered state, are never both high, and are high only in ISSUE. mgr_addr, mgr_wdata and mgr_sel stay stable from ISSUE through DONE.
- Latency: req high in IDLE at cycle 0 → strobe in cycle 1. With a manager that raises busy in cycle 2 and drops it in cycle k, done is in cycle k+1.
- Request handshake: a requester deasserts req on the edge that ends its done cycle. The arbiter does not sample req in ISSUE, WAIT_*, or DONE. A req still high in the IDLE following DONE is a new transaction.
- Starvation bound: a requester that stays asserted waits at most one foreign transaction (round-robin).
- rdata_x changes only on a completed read granted to x. Writes and timeouts leave it unchanged.
- Timed-out read: rdata unchanged, err pulse asserted.
- Reset mid-operation: immediate return to IDLE, strobes and pulses low. The in-flight transaction is abandoned with no done. The manager shares the same rst.
- Req dropped early (before done) is a protocol violation. The arbiter completes the latched transaction regardless.

Optional Feature:
- Macro: TEAM_06_SRAM_ARB_FIXED_PRIO_EN.
- Defined: requester A always wins when both request (strict priority for the real-time audio path). last_gnt is still updated but ignored. B can starve while A is continuously requesting.
- Undefined: round-robin as specified above.

Test Plan:
- Single A write: req_a=1, we_a=1, addr_a=0x3300_0010, wdata_a=0xDEAD_BEEF, sel_a=4'hF. Manager model busy for 3 cycles → mgr_write pulse exactly 1 cycle with those values; done_a 1 pulse; err_a=0; done_b never high.
- Single B read: read at 0x3300_0020 with mgr_rdata=0x1234_5678 when busy falls → rdata_b=0x1234_5678 at done_b; rdata_a stays 0.
- Simultaneous requests: req_a and req_b both held for 4 transactions → grant order A,B,A,B. With TEAM_06_SRAM_ARB_FIXED_PRIO_EN: A,A,A,A until req_a drops.
- Timeout: manager never raises busy → done_a and err_a pulse together exactly TIMEOUT_CYC cycles after the ISSUE cycle's successor; rdata_a unchanged; next transaction proceeds normally.
- Reset mid-transaction: rst=1 for 1 cycle during WAIT_DONE → next cycle state IDLE, all strobes and pulses 0, no done emitted; a subsequent req_b is served first (last_gnt=B reset, B sole requester).
- Strobe exclusivity: random 200-transaction mix → assertions that mgr_write & mgr_read is never 1, and each strobe lasts 1 cycle.

Source files
------------

// File: rtl/team_06_sram_arbiter_if.sv
// Bundle of requester A/B and wishbone_manager user-side signals for the SRAM arbiter.
// slave = arbiter view; master = environment view (both requesters plus the manager).
interface team_06_sram_arbiter_if;
  logic        req_a;
  logic        we_a;
  logic [31:0] addr_a;
  logic [31:0] wdata_a;
  logic [3:0]  sel_a;
  logic        done_a;
  logic        err_a;
  logic [31:0] rdata_a;

  logic        req_b;
  logic        we_b;
  logic [31:0] addr_b;
  logic [31:0] wdata_b;
  logic [3:0]  sel_b;
  logic        done_b;
  logic        err_b;
  logic [31:0] rdata_b;

  logic [31:0] mgr_wdata;
  logic [31:0] mgr_addr;
  logic [3:0]  mgr_sel;
  logic        mgr_write;
  logic        mgr_read;
  logic [31:0] mgr_rdata;
  logic        mgr_busy;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a, sel_a,
    input  req_b, we_b, addr_b, wdata_b, sel_b,
    input  mgr_rdata, mgr_busy,
    output done_a, err_a, rdata_a,
    output done_b, err_b, rdata_b,
    output mgr_wdata, mgr_addr, mgr_sel, mgr_write, mgr_read
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a, sel_a,
    output req_b, we_b, addr_b, wdata_b, sel_b,
    output mgr_rdata, mgr_busy,
    input  done_a, err_a, rdata_a,
    input  done_b, err_b, rdata_b,
    input  mgr_wdata, mgr_addr, mgr_sel, mgr_write, mgr_read
  );
endinterface

// File: rtl/team_06_sram_arbiter.sv
// Two-requester arbiter in front of wishbone_manager: round-robin grant, one-cycle strobe, busy tracking.
// Define TEAM_06_SRAM_ARB_FIXED_PRIO_EN to give requester A strict priority on ties.
module team_06_sram_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input logic                   clk,
  input logic                   rst,
  team_06_sram_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  logic [2:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_a_q, rdata_a_d;
  logic [31:0]      rdata_b_q, rdata_b_d;
  logic             pick_b;

`ifdef TEAM_06_SRAM_ARB_FIXED_PRIO_EN
  assign pick_b = bus.req_b & ~bus.req_a;
`else
  assign pick_b = bus.req_b & (~bus.req_a | (last_gnt_q == GNT_A));
`endif

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path through this block infers a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_a | bus.req_b) begin
          gnt_d   = pick_b ? GNT_B : GNT_A;
          we_d    = pick_b ? bus.we_b    : bus.we_a;
          addr_d  = pick_b ? bus.addr_b  : bus.addr_a;
          wdata_d = pick_b ? bus.wdata_b : bus.wdata_a;
          sel_d   = pick_b ? bus.sel_b   : bus.sel_a;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (bus.mgr_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Manager never acknowledged the strobe; finish with an error instead of hanging.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.mgr_busy) begin
          if (!we_q) begin
            if (gnt_q == GNT_B) rdata_b_d = bus.mgr_rdata;
            else                rdata_a_d = bus.mgr_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_gnt_d = gnt_q;
        err_d      = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= GNT_A;
      last_gnt_q <= GNT_B;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= 4'h0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  // Strobes and pulses decode purely from registered state, so they are glitch-free and mutually exclusive.
  assign bus.mgr_write = (state_q == S_ISSUE) &  we_q;
  assign bus.mgr_read  = (state_q == S_ISSUE) & ~we_q;
  assign bus.mgr_addr  = addr_q;
  assign bus.mgr_wdata = wdata_q;
  assign bus.mgr_sel   = sel_q;

  assign bus.done_a  = (state_q == S_DONE) & (gnt_q == GNT_A);
  assign bus.done_b  = (state_q == S_DONE) & (gnt_q == GNT_B);
  assign bus.err_a   = bus.done_a & err_q;
  assign bus.err_b   = bus.done_b & err_q;
  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;

endmodule

// File: tb/tb_team_06_sram_arbiter.sv
// Scoreboard bench for team_06_sram_arbiter: requester drivers push expectations, a negedge monitor
// pops them on done pulses; a manager model answers strobes (addresses 0xF... are never acknowledged).
module tb_team_06_sram_arbiter;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  team_06_sram_arbiter_if bus ();

  team_06_sram_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  bit          grant_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          strobe_cyc = 0;
  bit          prev_strobe = 1'b0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mgr_mem [logic [31:0]];
  logic [31:0] last_rd [2];
  logic [31:0] done_rd [2];
  bit          mgr_rand = 1'b0;
  int          mgr_dly = 1;
  int          mgr_len = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unwritten SRAM words read back as a fixed function of their address.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic bit cmd_match(input exp_t e);
    return (e.we == bus.mgr_write) && (e.addr == bus.mgr_addr) && (e.sel == bus.mgr_sel) &&
           (!e.we || (e.wdata == bus.mgr_wdata));
  endfunction

  // Manager model: acknowledges a strobe after a delay, stays busy, then returns data.
  initial begin
    int          mst;
    int          cnt;
    logic [31:0] maddr;
    logic        mwe;
    mst = 0;
    cnt = 0;
    maddr = '0;
    mwe = 1'b0;
    bus.mgr_busy  = 1'b0;
    bus.mgr_rdata = '0;
    forever begin
      tick();
      if (rst) begin
        bus.mgr_busy = 1'b0;
        mst = 0;
      end else begin
        case (mst)
          0: if ((bus.mgr_write | bus.mgr_read) && bus.mgr_addr[31:28] != 4'hF) begin
               maddr = bus.mgr_addr;
               mwe   = bus.mgr_write;
               if (mwe)
                 mgr_mem[maddr] = merge(mgr_mem.exists(maddr) ? mgr_mem[maddr] : dflt(maddr),
                                        bus.mgr_wdata, bus.mgr_sel);
               cnt = mgr_rand ? int'($urandom_range(16, 1)) : mgr_dly;
               mst = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 bus.mgr_busy = 1'b1;
                 cnt = mgr_rand ? int'($urandom_range(4, 1)) : mgr_len;
                 mst = 2;
               end
             end
          default: begin
               cnt--;
               if (cnt == 0) begin
                 bus.mgr_busy  = 1'b0;
                 bus.mgr_rdata = mwe ? $urandom : (mgr_mem.exists(maddr) ? mgr_mem[maddr] : dflt(maddr));
                 mst = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic handle_done(input bit which, input logic err_v, input logic [31:0] rd_own,
                             input logic [31:0] rd_other);
    exp_t e;
    if (which ? (q_b.size() == 0) : (q_a.size() == 0)) begin
      check(which ? "done_b_unexpected" : "done_a_unexpected", 32'd1, 32'd0);
    end else begin
      e = which ? q_b.pop_front() : q_a.pop_front();
      check(which ? "err_b" : "err_a", {31'd0, err_v}, {31'd0, e.err});
      check(which ? "rdata_b" : "rdata_a", rd_own, e.rdata);
      check("rdata_other_held", rd_other, done_rd[!which]);
      check("mgr_addr_stable", bus.mgr_addr, e.addr);
      check("mgr_sel_stable", {28'd0, bus.mgr_sel}, {28'd0, e.sel});
      done_rd[which] = e.rdata;
    end
  endtask

  // Monitor: strobe legality, strobe ownership, and done/err/rdata against the scoreboard.
  always @(negedge clk) begin
    logic strobe;
    bit   owned;
    strobe = bus.mgr_write | bus.mgr_read;
    if (strobe === 1'b1) begin
      check("strobe_excl", {31'd0, bus.mgr_write & bus.mgr_read}, 32'd0);
      check("strobe_1cyc", {31'd0, prev_strobe}, 32'd0);
      owned = 1'b0;
      if (q_a.size() > 0 && cmd_match(q_a[0])) begin
        grant_log.push_back(1'b0);
        owned = 1'b1;
      end else if (q_b.size() > 0 && cmd_match(q_b[0])) begin
        grant_log.push_back(1'b1);
        owned = 1'b1;
      end
      check("strobe_owner", {31'd0, owned}, 32'd1);
      strobe_cyc = cyc;
    end
    prev_strobe = (strobe === 1'b1);
    if ((bus.done_a === 1'b1) || (bus.done_b === 1'b1))
      check("done_excl", {31'd0, bus.done_a & bus.done_b}, 32'd0);
    if (bus.done_a === 1'b1) handle_done(1'b0, bus.err_a, bus.rdata_a, bus.rdata_b);
    if (bus.done_b === 1'b1) handle_done(1'b1, bus.err_b, bus.rdata_b, bus.rdata_a);
    if (((bus.err_a === 1'b1) && !bus.done_a) || ((bus.err_b === 1'b1) && !bus.done_b))
      check("err_without_done", 32'd1, 32'd0);
  end

  task automatic issue_txn(input bit which, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel, input bit keep,
                           output int t0, output int lat);
    exp_t e;
    bit   to;
    bit   got;
    to = (addr[31:28] == 4'hF);
    e.we = we;
    e.addr = addr;
    e.wdata = wdata;
    e.sel = sel;
    e.err = to;
    if (we) begin
      if (!to) ref_mem[addr] = merge(ref_rd(addr), wdata, sel);
      e.rdata = last_rd[which];
    end else begin
      e.rdata = to ? last_rd[which] : ref_rd(addr);
      last_rd[which] = e.rdata;
    end
    if (which) begin
      q_b.push_back(e);
      bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata; bus.sel_b = sel; bus.req_b = 1'b1;
    end else begin
      q_a.push_back(e);
      bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata; bus.sel_a = sel; bus.req_a = 1'b1;
    end
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      tick();
      if ((which ? bus.done_b : bus.done_a) === 1'b1) got = 1'b1;
    end
    if (!got) check("done_wait_expired", 32'd0, 32'd1);
    lat = cyc - t0;
    if (!keep) begin
      if (which) bus.req_b = 1'b0;
      else       bus.req_a = 1'b0;
    end
  endtask

  task automatic run_rand(input bit which, input int n);
    int t0, lat;
    bit keep;
    bit to;
    logic [31:0] base;
    keep = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!keep) repeat ($urandom_range(3, 0)) tick();
      keep = ($urandom_range(1, 0) == 1) && (i < n - 1);
      to   = ($urandom_range(9, 0) == 0);
      base = which ? (to ? 32'hF400_0000 : 32'h4400_0000) : (to ? 32'hF300_0000 : 32'h3300_0000);
      issue_txn(which, logic'($urandom_range(1, 0)), base + 32'($urandom_range(15, 0) * 4),
                $urandom, 4'($urandom_range(15, 1)), keep, t0, lat);
    end
  endtask

  task automatic run_seq(input bit which, input int n);
    int t0, lat;
    for (int i = 0; i < n; i++)
      issue_txn(which, 1'b1, (which ? 32'h4400_0100 : 32'h3300_0100) + 32'(i * 4),
                32'h1000_0000 * (i + 1) + (which ? 32'hB : 32'hA), 4'hF, i < n - 1, t0, lat);
  endtask

  task automatic do_reset();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    done_rd[0] = '0; done_rd[1] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat;
    bit got;
    bit exp_order[8];
    rst = 1'b1;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0; bus.sel_a = 4'h0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0; bus.sel_b = 4'h0;
    last_rd[0] = '0; last_rd[1] = '0;
    done_rd[0] = '0; done_rd[1] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_mgr_write", {31'd0, bus.mgr_write}, 32'd0);
    check("rst_mgr_read", {31'd0, bus.mgr_read}, 32'd0);
    check("rst_done", {30'd0, bus.done_a, bus.done_b}, 32'd0);
    check("rst_err", {30'd0, bus.err_a, bus.err_b}, 32'd0);
    check("rst_mgr_addr", bus.mgr_addr, 32'd0);
    check("rst_mgr_wdata", bus.mgr_wdata, 32'd0);
    check("rst_mgr_sel", {28'd0, bus.mgr_sel}, 32'd0);
    check("rst_rdata_a", bus.rdata_a, 32'd0);
    check("rst_rdata_b", bus.rdata_b, 32'd0);

    // Single A write: busy in cycle 2 for 3 cycles, done in cycle 6.
    issue_txn(1'b0, 1'b1, 32'h3300_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, t0, lat);
    check("a_write_strobe_cyc", 32'(strobe_cyc - t0), 32'd1);
    check("a_write_latency", 32'(lat), 32'd6);
    tick();

    // Single B read of a preloaded word.
    mgr_mem[32'h3300_0020] = 32'h1234_5678;
    ref_mem[32'h3300_0020] = 32'h1234_5678;
    issue_txn(1'b1, 1'b0, 32'h3300_0020, 32'h0, 4'hF, 1'b0, t0, lat);
    check("b_read_latency", 32'(lat), 32'd6);
    check("b_read_rdata", bus.rdata_b, 32'h1234_5678);
    tick();

    // Latest acknowledge that still beats the timeout.
    mgr_dly = TIMEOUT_CYC;
    mgr_len = 1;
    issue_txn(1'b0, 1'b0, 32'h3300_0010, 32'h0, 4'hF, 1'b0, t0, lat);
    check("late_ack_latency", 32'(lat), 32'(TIMEOUT_CYC + 3));
    mgr_dly = 1;
    mgr_len = 3;
    tick();

    // Timeout: done/err TIMEOUT_CYC cycles after the cycle following ISSUE.
    issue_txn(1'b0, 1'b0, 32'hF300_0040, 32'h0, 4'hF, 1'b0, t0, lat);
    check("timeout_latency", 32'(lat), 32'(TIMEOUT_CYC + 2));
    tick();
    issue_txn(1'b0, 1'b0, 32'h3300_0044, 32'h0, 4'h3, 1'b0, t0, lat);
    check("after_timeout_latency", 32'(lat), 32'd6);
    tick();

    // Simultaneous requests held for four transactions each.
    do_reset();
    grant_log.delete();
    fork
      run_seq(1'b0, 4);
      run_seq(1'b1, 4);
    join
    for (int i = 0; i < 8; i++) begin
`ifdef TEAM_06_SRAM_ARB_FIXED_PRIO_EN
      exp_order[i] = (i >= 4);
`else
      exp_order[i] = i[0];
`endif
    end
    check("grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("grant_order[%0d]", i), {31'd0, grant_log[i]}, {31'd0, exp_order[i]});
    tick();

    // Reset during WAIT_DONE abandons the transaction.
    mgr_len = 8;
    begin
      exp_t e;
      e.we = 1'b0; e.addr = 32'h3300_0030; e.wdata = '0; e.sel = 4'hF; e.err = 1'b0;
      e.rdata = ref_rd(32'h3300_0030);
      q_a.push_back(e);
    end
    bus.we_a = 1'b0; bus.addr_a = 32'h3300_0030; bus.sel_a = 4'hF; bus.req_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (bus.mgr_busy) got = 1'b1;
    end
    check("busy_seen_before_reset", {31'd0, got}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    bus.req_a = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_strobes", {30'd0, bus.mgr_write, bus.mgr_read}, 32'd0);
    check("midrst_pulses", {28'd0, bus.done_a, bus.done_b, bus.err_a, bus.err_b}, 32'd0);
    check("midrst_mgr_addr", bus.mgr_addr, 32'd0);
    q_a.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    done_rd[0] = '0; done_rd[1] = '0;
    mgr_len = 3;
    repeat (20) tick();
    issue_txn(1'b1, 1'b0, 32'h4400_0008, 32'h0, 4'hF, 1'b0, t0, lat);
    check("post_reset_b_latency", 32'(lat), 32'd6);
    tick();

    // Randomised mix: 200 transactions across both requesters.
    mgr_rand = 1'b1;
    fork
      run_rand(1'b0, 100);
      run_rand(1'b1, 100);
    join
    mgr_rand = 1'b0;
    repeat (5) tick();
    check("queues_drained", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
